// File: rtl/usb_fx3_pkg.sv
// Shared FX3 slave-FIFO constants: master modes, socket addresses and the
// stream-out FSM state encoding.
package usb_fx3_pkg;

    localparam logic [2:0] ModeLoopback  = 3'b000;
    localparam logic [2:0] ModeStreamOut = 3'b001;
    localparam logic [2:0] ModeStreamIn  = 3'b010;
    localparam logic [2:0] ModeZlp       = 3'b011;
    localparam logic [2:0] ModePartial   = 3'b100;
    localparam logic [2:0] ModeIdle      = 3'b101;

    localparam logic [1:0] SocketProducer = 2'b00;
    localparam logic [1:0] SocketConsumer = 2'b11;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StAddrSetup = 3'd1,
        StRead      = 3'd2,
        StReadTail  = 3'd3,
        StDrain     = 3'd4
    } stream_out_state_e;

endpackage

// File: rtl/usb_stream_out_fifo.sv
// First-word-fall-through capture FIFO for words read from the FX3 bus.
// rdata_o reads as zero while empty so the fabric never sees stale RAM contents.
module usb_stream_out_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [Width-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       rdata_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             full, do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == (PtrW + 1)'(Depth));
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push_i && (!full || do_pop);
    assign count_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PtrW + 1)'(1);
                2'b01:   count_q <= count_q - (PtrW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full && !pop_i))
        else $error("capture fifo overflow");

endmodule

// File: rtl/usb_stream_out.sv
// FX3 slave-FIFO stream-out reader: pulls words from the consumer socket into a
// skid FIFO, throttling SLRD so words already in flight always have a slot.
module usb_stream_out
    import usb_fx3_pkg::*;
#(
    parameter int unsigned READ_WATERMARK = 6,
    parameter int unsigned READ_LATENCY   = 2,
    parameter int unsigned SKID_DEPTH     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  master_mode,
    input  logic [31:0] DQ,
    input  logic        FLAGC,
    input  logic        FLAGD,
    output logic        SLCS,
    output logic        SLOE,
    output logic        SLRD,
    output logic        SLWR,
    output logic        PKTEND,
    output logic [1:0]  A,
    output logic [31:0] data_in,
    output logic        data_valid,
    input  logic        data_ready,
    output logic [2:0]  current_stream_out_mode
);

    localparam int unsigned CntW     = $clog2(SKID_DEPTH) + 1;
    localparam int unsigned TailW    = $clog2(READ_WATERMARK + 1) + 1;
    localparam int unsigned TailInit = (READ_WATERMARK > READ_LATENCY + 1) ?
                                       (READ_WATERMARK - READ_LATENCY - 1) : 0;

    stream_out_state_e        state_q, state_d;
    logic [TailW-1:0]         tail_q, tail_d;
    logic [READ_LATENCY-1:0]  pipe_q, pipe_d;
    logic                     live_q;
    logic [CntW-1:0]          fifo_count, inflight;
    logic                     fifo_empty, room, pending, stream_on, rd, sloe;

    assign stream_on = (master_mode == ModeStreamOut);

    always_comb begin
        inflight = '0;
        pending  = 1'b0;
        for (int i = 0; i < int'(READ_LATENCY); i++) begin
            inflight = inflight + CntW'(pipe_q[i]);
        end
        // The oldest stage lands on this edge, so only younger stages keep DRAIN waiting.
        for (int i = 0; i < int'(READ_LATENCY) - 1; i++) begin
            pending = pending | pipe_q[i];
        end
        room = ({1'b0, fifo_count} + {1'b0, inflight}) < (CntW + 1)'(SKID_DEPTH);
    end

    always_comb begin
        state_d = state_q;
        tail_d  = tail_q;
        rd      = 1'b0;
        sloe    = 1'b0;
        unique case (state_q)
            StIdle: begin
                sloe = 1'b1;
                if (stream_on && FLAGC) state_d = StAddrSetup;
            end
            StAddrSetup: begin
                state_d = stream_on ? StRead : StDrain;
            end
            StRead: begin
                if (!stream_on || !FLAGC) begin
                    state_d = StDrain;
                end else begin
                    rd = room;
                    if (!FLAGD) begin
                        tail_d  = TailW'(TailInit);
                        state_d = (TailInit == 0) ? StDrain : StReadTail;
                    end
                end
            end
            StReadTail: begin
                if (!stream_on) begin
                    state_d = StDrain;
                end else if (room) begin
                    rd     = 1'b1;
                    tail_d = tail_q - TailW'(1);
                    if (tail_q <= TailW'(1)) state_d = StDrain;
                end
            end
            StDrain: begin
                if (!pending) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        pipe_d    = pipe_q << 1;
        pipe_d[0] = rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tail_q  <= '0;
            pipe_q  <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tail_q  <= tail_d;
            pipe_q  <= pipe_d;
            live_q  <= 1'b1;
        end
    end

    assign SLCS   = ~live_q;
    assign SLOE   = sloe;
    assign SLRD   = ~rd;
    assign SLWR   = 1'b1;
    assign PKTEND = 1'b1;
    assign A      = SocketConsumer;
    assign data_valid = ~fifo_empty;
    assign current_stream_out_mode = state_q;

    usb_stream_out_fifo #(
        .Width (32),
        .Depth (SKID_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (pipe_q[READ_LATENCY-1]),
        .wdata_i (DQ),
        .pop_i   (data_valid && data_ready),
        .rdata_o (data_in),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: doc/usb_stream_out.md
USB_STREAM_OUT -- requirements
Module: usb_stream_out

Interface
REQ-001 SHALL have parameter READ_WATERMARK, default 6: FX3 consumer-socket watermark, in 32-bit words, programmed in firmware.
REQ-002 SHALL have parameter READ_LATENCY, default 2: cycles from SLRD sampled low to DQ valid.
REQ-003 SHALL have parameter SKID_DEPTH, default 8: capture FIFO depth, power of two, at least READ_LATENCY+2.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, ports named clk and rst_n.
REQ-005 SHALL have ports, in order:
- clk  in  1  clock, max 100 MHz
- rst_n  in  1  async active-low reset
- master_mode  in  3  mode select; 3'b001 is stream-out
- DQ  in  32  FX3 data bus (read side; tristate handled at top)
- FLAGC  in  1  1 = consumer socket has data
- FLAGD  in  1  watermark flag; 0 = at most READ_WATERMARK words remain
- SLCS, SLOE, SLRD, SLWR, PKTEND  out  1 each  FX3 strobes, all active-low
- A  out  2  FX3 socket address
- data_in  out  32  word to fabric
- data_valid  out  1  data_in is valid
- data_ready  in  1  fabric accepts the word
- current_stream_out_mode  out  3  state encoding, for debug

Function
REQ-006 SHALL hold SLWR=1 and PKTEND=1 at all times.
REQ-007 SHALL drive A=2'b11 and SLCS=0 in every state except reset.
REQ-008 SHALL have exactly these states: IDLE, ADDR_SETUP, READ, READ_TAIL, DRAIN.
REQ-009 IDLE: SLOE=1, SLRD=1; SHALL go to ADDR_SETUP when master_mode==3'b001 and FLAGC==1.
REQ-010 ADDR_SETUP: SLOE=0, SLRD=1; SHALL last exactly one cycle, then go to READ.
REQ-011 READ: SLOE=0; SLRD=0 only when fifo_count + inflight + 1 <= SKID_DEPTH; otherwise SLRD=1 (throttle without leaving READ).
REQ-012 READ: when FLAGD==0 is sampled, SHALL load tail_cnt = max(READ_WATERMARK - READ_LATENCY - 1, 0). If the loaded value is 0, go to DRAIN; otherwise go to READ_TAIL.
REQ-013 READ_TAIL: SLRD=0 for exactly tail_cnt cycles, with throttling per REQ-011 pausing the count; SHALL then go to DRAIN.
REQ-014 DRAIN: SLOE=0, SLRD=1 until inflight==0; SHALL then go to IDLE.
REQ-015 A READ_LATENCY-deep shift register of SLRD assertions SHALL track inflight words; when the delayed strobe is set, DQ SHALL be written into the capture FIFO.
REQ-016 When master_mode leaves 3'b001 in ADDR_SETUP, READ or READ_TAIL: SLRD=1 from the same cycle, go to DRAIN; no in-flight word SHALL be lost.
REQ-017 When FLAGC==0 is sampled in READ: SLRD=1 from the same cycle, go to DRAIN.
REQ-018 Capture FIFO output SHALL be first-word-fall-through: data_valid = !empty; a pop occurs on data_valid && data_ready.
REQ-019 A simultaneous push and pop SHALL leave the count unchanged. Pointers SHALL wrap modulo SKID_DEPTH.
REQ-020 The capture FIFO SHALL never overflow; an overflow is a design error flagged by assertion.
REQ-021 Words SHALL reach data_in in FX3 order, with no duplication or loss.

Reset
REQ-022 On rst_n low, asynchronously:
- state=IDLE
- SLCS=1, SLOE=1, SLRD=1, SLWR=1, PKTEND=1, A=2'b11
- FIFO empty, data_valid=0, data_in=0
- inflight=0, tail_cnt=0
REQ-023 Reset asserted mid-read SHALL discard in-flight words. After rst_n rises, the first SLRD=0 SHALL come no earlier than 2 cycles later.

Structure
REQ-024 Package usb_fx3_pkg SHALL hold the master_mode constants (loopback 000, stream_out 001, stream_in 010, ZLP 011, partial 100, idle 101), the socket addresses (producer 2'b00, consumer 2'b11) and the usb_stream_out state encoding.
REQ-025 The capture FIFO SHALL be the sub-module usb_stream_out_fifo, parameterised by width 32 and SKID_DEPTH.
REQ-026 All FX3-facing outputs SHALL be decoded from state and registered counters only; no combinational path from FX3 inputs to FX3 outputs except the same-cycle SLRD deassert in REQ-016/017.

Verification
REQ-027 Bench SHALL cover these directed scenarios:
- Mode 001, FLAGC=1, FLAGD falls after 20 reads, data_ready=1 -> exactly 20+3=23 SLRD-low cycles; words 0..22 appear in order; IDLE reached 2 cycles after last SLRD.
- data_ready=0 throughout a burst -> SLRD stops after 8 captured words; data_valid=1; no overflow; resumes in the cycle after the first pop.
- master_mode changes to 010 after 5 reads -> SLRD high the same cycle; 5 words delivered; state DRAIN then IDLE.
- READ_WATERMARK=2 -> tail_cnt=0; no READ_TAIL visit on FLAGD fall.
- rst_n pulsed low mid-READ -> all outputs at reset values within the same cycle; FIFO empty; no data_valid afterwards.
- Alternating data_ready at FIFO count 1 -> simultaneous push and pop; count stable; sequence intact.
